// File: rtl/alu_seq.sv
// Handshaked sequential ALU: 1-cycle logic/add/sub, bit-serial shifts, optional
// shift-add multiplier compiled in with ALU_SEQ_MUL_EN (opcode 1000 unsupported otherwise).
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             fZ,
  output logic             fC,
  output logic             fN,
  output logic             fV,
  output logic             err
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_ORR = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_LSR = 4'b0110;
  localparam logic [3:0] OP_LSL = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  logic [1:0]       r_state;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_w;
  logic [SHW:0]     r_cnt;
  logic [WIDTH-1:0] r_o;
  logic             r_fz, r_fc, r_fn, r_fv, r_err, r_ov;

  logic [WIDTH:0]   w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_res;
  logic             w_c, w_v, w_err, w_exec;
  logic [SHW-1:0]   w_n;
  logic [WIDTH-1:0] w_sh, w_fin;
  logic             w_shc, w_finc, w_last;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;
`endif

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_ov;
  assign o         = r_o;
  assign fZ        = r_fz;
  assign fC        = r_fc;
  assign fN        = r_fn;
  assign fV        = r_fv;
  assign err       = r_err;

  assign w_add  = {1'b0, a} + {1'b0, b};
  assign w_sub  = a - b;
  assign w_n    = b[SHW-1:0];
  assign w_last = (r_cnt == (SHW+1)'(1));

  // Result for ops that finish on the accept edge; w_exec marks iterative ops.
  always_comb begin
    w_res  = '0;
    w_c    = 1'b0;
    w_v    = 1'b0;
    w_err  = 1'b0;
    w_exec = 1'b0;
    case (op)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub;
        w_c   = (a >= b);
        w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: w_res = a & b;
      OP_ORR: w_res = a | b;
      OP_NOT: w_res = ~a;
      OP_XOR: w_res = a ^ b;
      OP_LSR, OP_LSL: begin
        w_res  = a;
        w_exec = (w_n != '0);
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: w_exec = 1'b1;
`endif
      default: w_err = 1'b1;
    endcase
  end

  // One iteration of the shifter or multiplier; w_fin/w_finc are final on the last step.
  always_comb begin
    w_sh   = (r_op == OP_LSL) ? {r_w[WIDTH-2:0], 1'b0} : {1'b0, r_w[WIDTH-1:1]};
    w_shc  = (r_op == OP_LSL) ? r_w[WIDTH-1] : r_w[0];
    w_fin  = w_sh;
    w_finc = w_shc;
`ifdef ALU_SEQ_MUL_EN
    w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_w} : '0);
    w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
    if (r_op == OP_MUL) begin
      w_fin  = w_prod_nxt[WIDTH-1:0];
      w_finc = |w_prod_nxt[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_w     <= '0;
      r_cnt   <= '0;
      r_o     <= '0;
      r_fz    <= 1'b0;
      r_fc    <= 1'b0;
      r_fn    <= 1'b0;
      r_fv    <= 1'b0;
      r_err   <= 1'b0;
      r_ov    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_prod  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op <= op;
          r_w  <= a;
          if (w_exec) begin
            r_cnt   <= {1'b0, w_n};
            r_state <= S_EXEC;
`ifdef ALU_SEQ_MUL_EN
            r_prod  <= {{WIDTH{1'b0}}, b};
            if (op == OP_MUL) r_cnt <= (SHW+1)'(WIDTH);
`endif
          end else begin
            r_o     <= w_res;
            r_fz    <= (w_res == '0);
            r_fn    <= w_res[WIDTH-1];
            r_fc    <= w_c;
            r_fv    <= w_v;
            r_err   <= w_err;
            r_ov    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_EXEC: begin
          r_cnt <= r_cnt - (SHW+1)'(1);
`ifdef ALU_SEQ_MUL_EN
          if (r_op == OP_MUL) r_prod <= w_prod_nxt;
          else                r_w    <= w_sh;
`else
          r_w <= w_sh;
`endif
          if (w_last) begin
            r_o     <= w_fin;
            r_fz    <= (w_fin == '0);
            r_fn    <= w_fin[WIDTH-1];
            r_fc    <= w_finc;
            r_fv    <= 1'b0;
            r_err   <= 1'b0;
            r_ov    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: if (out_ready) begin
          r_ov    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the CPU's 16-bit combinational ALU. Accepts one operation at a time over a valid/ready input port and returns a registered result with Z/C/N/V flags over a valid/ready output port. Logic and add/sub ops complete in one cycle. Shifts take a variable shift amount and execute one bit per cycle. An optional shift-add multiplier is compiled in by macro. It sits between the decode stage and the register-file writeback in the multi-cycle datapath.

## Interface
- WIDTH, 16, operand/result width; power of two, minimum 4.
- SHW, $clog2(WIDTH), derived shift-amount field width; not overridden.

- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  = (state==IDLE) && !rst.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; for shifts only b[SHW-1:0] is the amount.
- op  in  4  opcode.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- o  out  WIDTH  result.
- fZ, fC, fN, fV  out  1 each  zero, carry, negative, overflow.
- err  out  1  unsupported opcode (qualified by out_valid).

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB (a-b)
  - 0010 AND
  - 0011 ORR
  - 0100 NOT (~a)
  - 0101 XOR
  - 0110 LSR
  - 0111 LSL
  - 1000 MUL (macro-dependent)
  - all others unsupported.
- Accept: on in_valid && in_ready, latch a, b, op, and the shift count n=b[SHW-1:0]. Inputs are ignored at all other times.
- State machine:
  - IDLE -> DONE: single-cycle ops, unsupported ops, shifts with n==0.
  - IDLE -> EXEC: shifts with n>0, MUL.
  - EXEC -> DONE: when the iteration counter reaches 0.
  - DONE -> IDLE: on out_valid && out_ready.
- EXEC, shifts: shift the working register by 1 each cycle and decrement the counter; exactly n cycles.
- EXEC, MUL: radix-2 shift-add over 2*WIDTH product; exactly WIDTH cycles.
- Flags (all written on entry to DONE):
  - fZ = (o==0).
  - fN = o[WIDTH-1].
  - ADD: fC = carry out; fV = signed overflow.
  - SUB: fC = 1 when a >= b unsigned (no borrow); fV = signed overflow.
  - LSR/LSL: fC = last bit shifted out, 0 when n==0; fV = 0.
  - AND/ORR/NOT/XOR: fC = fV = 0.
  - MUL: o = low WIDTH bits; fC = 1 when the high WIDTH bits are nonzero; fV = 0.
  - Unsupported: o = 0, fZ = 1, other flags 0, err = 1. err = 0 otherwise.
- o, flags, and err are held stable while out_valid=1 and out_ready=0.
- Reset (asynchronous, any state, including mid-EXEC):
  - state = IDLE.
  - o = 0, fZ = fC = fN = fV = 0, err = 0, out_valid = 0.
  - Counters and working registers cleared; the in-flight op is discarded.
  - in_ready = 0 while rst is high and 1 on the first cycle after release.

## Timing
- Latency, measured from the accept edge to out_valid high:
  - single-cycle ops: 1 cycle.
  - shifts: 1+n cycles.
  - MUL: 1+WIDTH cycles.
- out_valid is asserted on the same edge that enters DONE.
- in_ready falls on the accept edge.
- in_ready rises on the edge after the output handshake; no same-cycle re-accept.
- Peak throughput: one single-cycle op per 2 cycles.
- out_ready is ignored outside DONE.
- in_valid is ignored outside IDLE.

## Configuration
- ALU_SEQ_MUL_EN defined: opcode 1000 performs MUL as above, taking WIDTH EXEC cycles.
- ALU_SEQ_MUL_EN undefined:
  - no multiplier datapath or product register is synthesised.
  - 1000 is an unsupported opcode (o=0, fZ=1, err=1, 1-cycle latency).

## Test plan
- WIDTH=16, ADD a=0x0001, b=0x0002 -> o=0x0003, fZ=0, fC=0, fN=0, fV=0, out_valid 1 cycle after accept. ADD a=0x7FFF, b=0x0001 -> o=0x8000, fN=1, fV=1.
- SUB a=0x0001, b=0x0001 -> o=0x0000, fZ=1, fC=1. SUB a=0x0000, b=0x0001 -> o=0xFFFF, fN=1, fC=0.
- LSL a=0x8001, b=0x0003 -> o=0x0008, fC=0, out_valid exactly 4 cycles after accept. LSR a=0x0002, b=0x0000 -> o=0x0002, fC=0, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after AND a=0x0006, b=0x0005 -> o=0x0004 stable and in_ready=0 throughout. in_ready=1 the cycle after out_ready pulses.
- Reset mid-op: assert rst on the 3rd EXEC cycle of LSL by 10. All outputs read 0 asynchronously and out_valid never rises for that op. After release, XOR a=0x0006, b=0x0005 -> o=0x0003.
- With ALU_SEQ_MUL_EN: MUL a=0x0100, b=0x0101 -> o=0x0100, fC=1, latency 17. Without the macro: MUL -> o=0, fZ=1, err=1, latency 1.
